// File: rtl/pipeline_hazard_sequencer.sv
// Stall/flush sequencer for a 5-stage pipeline: drives latch enables/flushes and
// the PC enable, and counts cycles in which the PC was held.
module pipeline_hazard_sequencer #(
   parameter int CNT_W = 16,
   parameter int REG_W = 5
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             ihit,
   input  logic             dhit,
   input  logic             dmemREN,
   input  logic             dmemWEN,
   input  logic             idex_mem2reg,
   input  logic [REG_W-1:0] idex_rd,
   input  logic [REG_W-1:0] ifid_rs,
   input  logic [REG_W-1:0] ifid_rt,
   input  logic             ifid_uses_rt,
   input  logic             jump_id,
   input  logic             branch_taken,
   input  logic             memwb_halt,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             idex_en,
   output logic             exmem_en,
   output logic             memwb_en,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             exmem_flush,
   output logic             memwb_flush,
   output logic             halted,
   output logic [CNT_W-1:0] stall_cnt
);

   typedef enum logic [1:0] {S_RUN, S_MEMWAIT, S_HALT} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             memstall, load_use, advance;
   logic             pc_raw;

   assign memstall = (dmemREN | dmemWEN) & ~dhit;
   assign load_use = idex_mem2reg && (idex_rd != '0) &&
                     ((idex_rd == ifid_rs) || (ifid_uses_rt && (idex_rd == ifid_rt)));

   always_comb begin
      // NOTE: every output gets a default first so no path leaves a latch behind.
      state_d     = state_q;
      advance     = 1'b0;
      pc_raw      = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_en    = 1'b0;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      exmem_flush = 1'b0;
      memwb_flush = 1'b0;
      halted      = 1'b0;

      unique case (state_q)
         S_RUN: begin
            if (memwb_halt)    state_d = S_HALT;
            else if (memstall) state_d = S_MEMWAIT;
            else               advance = 1'b1;
         end
         // halt cannot newly appear in MEM/WB while it is frozen, so it is not looked at here
         S_MEMWAIT: begin
            if (!memstall) begin
               state_d = S_RUN;
               advance = 1'b1;
            end
         end
         S_HALT:  halted = 1'b1;
         default: state_d = S_RUN;
      endcase

      if (advance) begin
         {ifid_en, idex_en, exmem_en, memwb_en} = 4'b1111;
         if (branch_taken) begin
            {ifid_flush, idex_flush, exmem_flush} = 3'b111;
            pc_raw = 1'b1;
         end else if (load_use) begin
            // jump waits: holding IF/ID keeps it visible until the load clears
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
         end else if (jump_id) begin
            ifid_flush = 1'b1;
            pc_raw     = ihit;
         end else if (!ihit) begin
            ifid_flush = 1'b1;
         end else begin
            pc_raw = 1'b1;
         end
      end

      pc_en = pc_raw;
      if (RST) begin
         {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '0;
         {ifid_flush, idex_flush, exmem_flush, memwb_flush, halted} = '0;
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if ((state_q != S_HALT) && !pc_raw && (cnt_q != '1))
         cnt_d = cnt_q + CNT_W'(1);
   end

   // NOTE: sequential state uses non-blocking assignments only, so every register
   // samples its pre-edge value.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= S_RUN;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign stall_cnt = cnt_q;

endmodule
